// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Imported by the loader top level and its word packer.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // A header is usable when 1 <= n <= 2**pc_size words.
    function automatic logic len_ok(
        input logic [LEN_BYTES*8-1:0] n,
        input int unsigned            pc_size
    );
        return (n != '0) && (32'(n) <= (32'd1 << pc_size));
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-wide valid/ready stream feeding the program loader.
// master = upstream byte source, slave = loader.
interface program_loader_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );

endinterface

// File: rtl/loader_word_packer.sv
// Collects little-endian bytes into 32-bit words for the loader.
// word already includes the byte being loaded, so it is valid with word_done.
module loader_word_packer
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int IW = $clog2(WORD_BYTES);

    logic [IW-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]    lane_q [WORD_BYTES];
    logic [7:0]    lane_d [WORD_BYTES];

    always_comb begin
        byte_idx_d = byte_idx_q;
        lane_d     = lane_q;
        if (clear) begin
            byte_idx_d = '0;
        end else if (load) begin
            lane_d[byte_idx_q] = byte_data;
            byte_idx_d         = byte_idx_q + 1'b1;
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            word[8*i +: 8] = (load && byte_idx_q == IW'(i)) ? byte_data : lane_q[i];
        end
    end

    assign word_done = load && (byte_idx_q == IW'(WORD_BYTES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx_q <= '0;
            for (int i = 0; i < WORD_BYTES; i++) lane_q[i] <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            lane_q     <= lane_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program image into instruction memory,
// holding the core in reset until the whole image has been written.
module program_loader
    import loader_pkg::*;
#(
    parameter int PC_SIZE = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    program_loader_if.slave     byte_if,
    output logic                imem_we,
    output logic [PC_SIZE-1:0]  PC_write,
    output logic [31:0]         instruction_in,
    output logic                reset_IF_memory,
    output logic                core_reset,
    output logic                done,
    output logic                error
);

    state_e               state_q, state_d;
    logic [7:0]           len_lo_q, len_lo_d;
    logic [PC_SIZE-1:0]   last_q, last_d;
    logic [PC_SIZE-1:0]   cnt_q, cnt_d;
    logic [PC_SIZE-1:0]   pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;

    logic                 ready;
    logic                 fire;
    logic                 pk_clear;
    logic                 pk_load;
    logic                 word_done;
    logic [31:0]          word;
    logic [LEN_BYTES*8-1:0] hdr;

    assign ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                   (state_q == ST_DATA);
    assign fire  = byte_if.byte_valid && ready;
    assign hdr   = {byte_if.byte_data, len_lo_q};

    assign byte_if.byte_ready = ready;

    loader_word_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (pk_clear),
        .load      (pk_load),
        .byte_data (byte_if.byte_data),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pk_clear = 1'b0;
        pk_load  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                cnt_d    = '0;
                pk_clear = 1'b1;
                state_d  = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (fire) begin
                    len_lo_d = byte_if.byte_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (fire) begin
                    if (len_ok(hdr, PC_SIZE)) begin
                        last_d  = PC_SIZE'(hdr - 1'b1);
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DATA: begin
                pk_load = fire;
                // Latch address and data now so they hold after the write.
                if (word_done) begin
                    pc_d    = cnt_q;
                    instr_d = word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                pk_clear = 1'b1;
                if (cnt_q == last_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_CLEAR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_we         = (state_q == ST_WRITE);
    assign reset_IF_memory = (state_q == ST_CLEAR);
    assign core_reset      = (state_q != ST_DONE);
    assign done            = (state_q == ST_DONE);
    assign error           = (state_q == ST_ERROR);
    assign PC_write        = pc_q;
    assign instruction_in  = instr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader.
// Expected writes come from the image words: word i lands at address i.
module tb_program_loader;

    localparam int PC_SIZE = 10;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic               imem_we;
    logic [PC_SIZE-1:0] PC_write;
    logic [31:0]        instruction_in;
    logic               reset_IF_memory;
    logic               core_reset;
    logic               done;
    logic               error;

    program_loader_if bif ();

    program_loader #(.PC_SIZE(PC_SIZE)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .byte_if         (bif),
        .imem_we         (imem_we),
        .PC_write        (PC_write),
        .instruction_in  (instruction_in),
        .reset_IF_memory (reset_IF_memory),
        .core_reset      (core_reset),
        .done            (done),
        .error           (error)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;
    int rif_cnt = 0;

    logic [PC_SIZE-1:0] obs_addr [$];
    logic [31:0]        obs_data [$];
    logic [31:0]        img_words [$];
    logic [7:0]         tx [$];
    logic [7:0]         tx_full [$];

    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            obs_addr.push_back(PC_write);
            obs_data.push_back(instruction_in);
        end
        if (reset_IF_memory === 1'b1) rif_cnt++;
    end

    // Image = 16-bit word count (low byte first), then words little-endian.
    task automatic build_tx(input int unsigned n_hdr);
        tx.delete();
        tx.push_back(n_hdr[7:0]);
        tx.push_back(n_hdr[15:8]);
        foreach (img_words[w]) begin
            for (int b = 0; b < 4; b++) tx.push_back(img_words[w][8*b +: 8]);
        end
    endtask

    task automatic rand_words(input int n);
        img_words.delete();
        for (int i = 0; i < n; i++) img_words.push_back($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        rif_cnt = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Offers tx bytes one per cycle, idling with probability drop_pct.
    task automatic send_tx(input int drop_pct, output int cycles, output bit timed_out);
        int i = 0;
        int budget = 10 * tx.size() + 50;
        bit acc;
        cycles = 0;
        while (i < tx.size() && cycles < budget) begin
            bif.byte_data  = tx[i];
            bif.byte_valid = ($urandom_range(99) >= drop_pct);
            @(negedge clock);
            acc = bif.byte_valid && bif.byte_ready;
            @(posedge clock);
            #1;
            if (acc) i++;
            cycles++;
        end
        bif.byte_valid = 1'b0;
        timed_out = (i < tx.size());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_total++;
        if ({core_reset, bif.byte_ready, imem_we, reset_IF_memory, done, error} !== 6'b100000)
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {core_reset, bif.byte_ready, imem_we, reset_IF_memory, done, error});
        else n_pass++;
        n_total++;
        if ({PC_write, instruction_in} !== '0)
            $display("FAIL reset_bus: got %h/%h expected 0/0", PC_write, instruction_in);
        else n_pass++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        rif_cnt = 0;
        obs_addr.delete();
        obs_data.delete();
        do_start();
        @(negedge clock);
        n_total++;
        if ({reset_IF_memory, bif.byte_ready} !== 2'b10)
            $display("FAIL clear_cycle: got rif,ready=%b expected 10", {reset_IF_memory, bif.byte_ready});
        else n_pass++;
        @(posedge clock);
        #1;
        @(negedge clock);
        n_total++;
        if ({reset_IF_memory, bif.byte_ready} !== 2'b01)
            $display("FAIL len_ready: got rif,ready=%b expected 01", {reset_IF_memory, bif.byte_ready});
        else n_pass++;
        repeat (5) @(posedge clock);
        #1;
        n_total++;
        if (rif_cnt !== 1 || obs_addr.size() !== 0)
            $display("FAIL idle_wait: got rif=%0d writes=%0d expected 1/0", rif_cnt, obs_addr.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        do_reset();
        img_words = '{32'h00500513, 32'h00B505B3};
        build_tx(2);
        do_start();
        send_tx(0, cyc, to);
        n_total++;
        if (to || cyc !== 12)
            $display("FAIL b2b_cycles: got %0d (timeout %0d) expected 12", cyc, to);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if ({imem_we, done, core_reset} !== 3'b101)
            $display("FAIL b2b_last_write: got we,done,cr=%b expected 101", {imem_we, done, core_reset});
        else n_pass++;
        @(posedge clock);
        #1;
        @(negedge clock);
        n_total++;
        if ({imem_we, done, core_reset, bif.byte_ready} !== 4'b0100)
            $display("FAIL b2b_done: got we,done,cr,rdy=%b expected 0100",
                     {imem_we, done, core_reset, bif.byte_ready});
        else n_pass++;
        n_total++;
        if (obs_addr.size() !== 2)
            $display("FAIL b2b_count: got %0d writes expected 2", obs_addr.size());
        else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            n_total++;
            if (obs_addr[i] !== PC_SIZE'(i) || obs_data[i] !== img_words[i])
                $display("FAIL b2b_write%0d: got %0d/%h expected %0d/%h",
                         i, obs_addr[i], obs_data[i], i, img_words[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random_gaps();
        int cyc;
        bit to;
        for (int rep = 0; rep < 4; rep++) begin
            do_reset();
            if (rep == 0) img_words = '{32'h00500513, 32'h00B505B3};
            else rand_words($urandom_range(1, 8));
            build_tx(img_words.size());
            do_start();
            send_tx(40, cyc, to);
            repeat (2) @(posedge clock);
            #1;
            n_total++;
            if (to || done !== 1'b1 || obs_addr.size() !== img_words.size())
                $display("FAIL gaps%0d_count: got writes=%0d done=%b to=%0d expected %0d/1/0",
                         rep, obs_addr.size(), done, to, img_words.size());
            else n_pass++;
            for (int i = 0; i < obs_addr.size() && i < img_words.size(); i++) begin
                n_total++;
                if (obs_addr[i] !== PC_SIZE'(i) || obs_data[i] !== img_words[i])
                    $display("FAIL gaps%0d_write%0d: got %0d/%h expected %0d/%h",
                             rep, i, obs_addr[i], obs_data[i], i, img_words[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bad_len();
        int cyc;
        bit to;
        do_reset();
        img_words.delete();
        build_tx(0);
        do_start();
        send_tx(0, cyc, to);
        @(negedge clock);
        n_total++;
        if (to || {error, bif.byte_ready, core_reset, done} !== 4'b1010)
            $display("FAIL len_zero: got err,rdy,cr,done=%b expected 1010",
                     {error, bif.byte_ready, core_reset, done});
        else n_pass++;
        @(posedge clock);
        #1;
        do_start();
        @(negedge clock);
        n_total++;
        if ({error, reset_IF_memory} !== 2'b01)
            $display("FAIL err_restart: got err,rif=%b expected 01", {error, reset_IF_memory});
        else n_pass++;
        @(posedge clock);
        #1;
        build_tx(1 << PC_SIZE + 1);
        build_tx((1 << PC_SIZE) + 1);
        send_tx(30, cyc, to);
        @(negedge clock);
        n_total++;
        if (to || {error, bif.byte_ready, obs_addr.size() == 0} !== 3'b101)
            $display("FAIL len_over: got err=%b rdy=%b writes=%0d expected 1/0/0",
                     error, bif.byte_ready, obs_addr.size());
        else n_pass++;
    endtask

    task automatic test_max_len();
        int cyc;
        bit to;
        int bad = 0;
        do_reset();
        rand_words(1 << PC_SIZE);
        build_tx(1 << PC_SIZE);
        do_start();
        send_tx(0, cyc, to);
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if (to || done !== 1'b1 || obs_addr.size() !== (1 << PC_SIZE))
            $display("FAIL max_count: got writes=%0d done=%b to=%0d expected %0d/1/0",
                     obs_addr.size(), done, to, 1 << PC_SIZE);
        else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < img_words.size(); i++) begin
            if (obs_addr[i] !== PC_SIZE'(i) || obs_data[i] !== img_words[i]) bad++;
        end
        n_total++;
        if (bad != 0)
            $display("FAIL max_data: got %0d wrong writes expected 0", bad);
        else n_pass++;
        n_total++;
        if (PC_write !== {PC_SIZE{1'b1}})
            $display("FAIL max_last_addr: got %0d expected %0d", PC_write, (1 << PC_SIZE) - 1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit to;
        do_reset();
        rand_words(2);
        build_tx(2);
        tx_full = tx;
        tx = tx_full[0:4];
        do_start();
        send_tx(0, cyc, to);
        bif.byte_valid = 1'b1;
        bif.byte_data  = tx_full[5];
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        bif.byte_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if ({imem_we, core_reset, bif.byte_ready} !== 3'b010)
            $display("FAIL mid_reset_idle: got we,cr,rdy=%b expected 010",
                     {imem_we, core_reset, bif.byte_ready});
        else n_pass++;
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if (to || obs_addr.size() !== 0)
            $display("FAIL mid_reset_nowrite: got %0d writes expected 0", obs_addr.size());
        else n_pass++;
        tx = tx_full;
        do_start();
        send_tx(20, cyc, to);
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if (to || done !== 1'b1 || obs_addr.size() !== 2)
            $display("FAIL mid_reload_count: got writes=%0d done=%b expected 2/1", obs_addr.size(), done);
        else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            n_total++;
            if (obs_addr[i] !== PC_SIZE'(i) || obs_data[i] !== img_words[i])
                $display("FAIL mid_reload_write%0d: got %0d/%h expected %0d/%h",
                         i, obs_addr[i], obs_data[i], i, img_words[i]);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        bit to;
        do_reset();
        rand_words(2);
        build_tx(2);
        tx_full = tx;
        tx = tx_full[0:3];
        do_start();
        send_tx(0, cyc, to);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        n_total++;
        if ({bif.byte_ready, reset_IF_memory} !== 2'b10)
            $display("FAIL data_start: got rdy,rif=%b expected 10", {bif.byte_ready, reset_IF_memory});
        else n_pass++;
        @(posedge clock);
        #1;
        tx = tx_full[4:$];
        send_tx(25, cyc, to);
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if (to || rif_cnt !== 1 || done !== 1'b1 || obs_addr.size() !== 2)
            $display("FAIL data_start_load: got rif=%0d done=%b writes=%0d expected 1/1/2",
                     rif_cnt, done, obs_addr.size());
        else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            n_total++;
            if (obs_addr[i] !== PC_SIZE'(i) || obs_data[i] !== img_words[i])
                $display("FAIL data_start_write%0d: got %0d/%h expected %0d/%h",
                         i, obs_addr[i], obs_data[i], i, img_words[i]);
            else n_pass++;
        end
        do_start();
        @(negedge clock);
        n_total++;
        if ({core_reset, done, reset_IF_memory} !== 3'b101)
            $display("FAIL done_restart: got cr,done,rif=%b expected 101",
                     {core_reset, done, reset_IF_memory});
        else n_pass++;
        @(posedge clock);
        #1;
        obs_addr.delete();
        obs_data.delete();
        rand_words(1);
        build_tx(1);
        send_tx(30, cyc, to);
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if (to || done !== 1'b1 || obs_addr.size() !== 1)
            $display("FAIL reload_count: got writes=%0d done=%b expected 1/1", obs_addr.size(), done);
        else n_pass++;
        if (obs_addr.size() > 0) begin
            n_total++;
            if (obs_addr[0] !== '0 || obs_data[0] !== img_words[0])
                $display("FAIL reload_write: got %0d/%h expected 0/%h", obs_addr[0], obs_data[0], img_words[0]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random_gaps();
        test_bad_len();
        test_max_len();
        test_reset_mid();
        test_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image into the core's instruction memory over a byte-wide valid/ready link, such as a UART receiver. It holds the core in reset while loading, then releases it. The block is the writer side of the instruction-memory load port (`PC_write` / `instruction_in` / `reset_IF_memory`) that the fetch stage reads from. It assembles little-endian 32-bit words, writes them at consecutive addresses from 0, and reports done or error.

## Interface
Parameters:
- `PC_SIZE`, 10: instruction address width; maximum image size is 2**PC_SIZE words.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request to begin a load session.
- `byte_valid`  in  1  upstream byte available.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `PC_write`  out  PC_SIZE  write address (word index).
- `instruction_in`  out  32  write data.
- `reset_IF_memory`  out  1  high for exactly the first cycle of a session; clears instruction memory.
- `core_reset`  out  1  drives the core `reset`; high except in DONE.
- `done`  out  1  level; image fully written.
- `error`  out  1  level; bad length header.

## Operation
- Image format:
  - length header N: 2 bytes, low byte first, in words.
  - then 4·N data bytes; each word is little-endian (first byte → bits [7:0]).
- States: IDLE, CLEAR, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
- IDLE: `core_reset`=1. On `start` → CLEAR.
- CLEAR: one cycle with `reset_IF_memory`=1; clears the word counter and byte index → LEN_LO.
- LEN_LO, LEN_HI: accept one byte each.
  - After LEN_HI: if N==0 or N>2**PC_SIZE → ERROR.
  - Otherwise store N−1 (PC_SIZE bits) → DATA.
- DATA: accept bytes into lane `byte_idx` (2-bit counter). The 4th accepted byte → WRITE.
- WRITE: one cycle with `imem_we`=1, `PC_write`=word counter, `instruction_in`=assembled word.
  - If counter==N−1 → DONE.
  - Else counter+1, `byte_idx`=0 → DATA.
- DONE: `done`=1, `core_reset`=0. On `start` → CLEAR (`core_reset` reasserts in the same cycle as the state change).
- ERROR: `error`=1, `core_reset`=1. On `start` → CLEAR.
- `start` is ignored in CLEAR, LEN_*, DATA and WRITE.
- `done` and `error` clear on entry to CLEAR.
- A byte transfers only when `byte_valid && byte_ready`. `byte_ready` is high only in LEN_LO, LEN_HI and DATA.
- Upstream may drop `byte_valid` at any cycle; the loader waits indefinitely with no timeout.
- Address width: the counter is PC_SIZE bits. N==2**PC_SIZE ends at address 2**PC_SIZE−1 with no wrap.

## Timing
- Reset values:
  - `core_reset`=1.
  - `byte_ready`, `imem_we`, `reset_IF_memory`, `done`, `error` = 0.
  - `PC_write`=0, `instruction_in`=0, state IDLE.
- Reset mid-session: returns to IDLE next cycle. Partial words are discarded; no `imem_we` is issued.
- `start` registered in cycle t → `reset_IF_memory` high in t+1 → `byte_ready` high from t+2.
- 4th byte of a word accepted in cycle t → `imem_we` in t+1 → `byte_ready` high again in t+2.
  - Sustained throughput: 4 bytes per 5 cycles.
- Final WRITE in cycle t → `done`=1 and `core_reset`=0 from t+1.
- `PC_write` and `instruction_in` hold their last value outside WRITE.

## Structure
- Shared package `loader_pkg`:
  - state enum;
  - `LEN_BYTES`=2, `WORD_BYTES`=4.
- Sub-module `loader_word_packer`:
  - `byte_idx` counter plus 4×8 lane register;
  - clear, load-lane and word-complete strobes.
- The top level holds the FSM, length register and word counter.

## Test plan
- Reset: all outputs at reset values. `start` with `byte_valid`=0 → `reset_IF_memory` pulses once, then `byte_ready`=1, no writes.
- Bytes 02 00 13 05 50 00 B3 05 B5 00 sent back-to-back → writes (0, 0x00500513), then (1, 0x00B505B3); `done`=1 and `core_reset`=0 the cycle after the 2nd write.
- Same image with `byte_valid` randomly deasserted → identical writes; `imem_we` never fires twice for one word.
- Header 00 00 → `error`=1 and `byte_ready`=0. Header 01 04 (1025) with PC_SIZE=10 → `error`=1.
- Reset after the 6th byte → IDLE, no `imem_we`. A new `start` plus image loads correctly from address 0.
- `start` during DATA → ignored. `start` in DONE → `core_reset`=1 and `done`=0 next cycle; a 1-word reload writes addr 0.
